cache_fill_fsm: RTL



---
 rtl/cache_fill_fsm.sv | 117 +++++++++++
 1 files changed

// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, streams WORDS_PER_LINE pipelined reads and writes data then tag.
// Optional macro CRITICAL_WORD_FIRST_EN starts the fill at the missing word and wraps within the line.
module cache_fill_fsm #(
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read_req,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] fill_word_addr,
  output logic [15:0]       fill_data,
  output logic              write_tag_array
);
  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = IDX_W + 1;  // byte-offset bits within a line
  localparam logic [CNT_W-1:0] CNT_WPL  = CNT_W'(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d, recv_cnt_q, recv_cnt_d;
  logic [IDX_W-1:0]  issue_idx, recv_idx;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] offset_q, offset_d;
  // IDX_W-bit sum wraps modulo the line, so no carry leaves the line
  assign issue_idx = offset_q + issue_cnt_q[IDX_W-1:0];
  assign recv_idx  = offset_q + recv_cnt_q[IDX_W-1:0];
`else
  assign issue_idx = issue_cnt_q[IDX_W-1:0];
  assign recv_idx  = recv_cnt_q[IDX_W-1:0];
`endif

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
`ifdef CRITICAL_WORD_FIRST_EN
    offset_d         = offset_q;
`endif
    fsm_busy         = 1'b0;
    memory_read_req  = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    memory_address   = base_q + {{(ADDR_W-OFF_W){1'b0}}, issue_idx, 1'b0};
    fill_word_addr   = base_q + {{(ADDR_W-OFF_W){1'b0}}, recv_idx, 1'b0};
    fill_data        = memory_data;
    case (state_q)
      IDLE: begin
        fsm_busy = miss_detected;
        if (miss_detected) begin
          base_d      = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
`ifdef CRITICAL_WORD_FIRST_EN
          offset_d    = miss_address[OFF_W-1:1];
`endif
          state_d     = FILL;
        end
      end
      FILL: begin
        fsm_busy        = 1'b1;
        memory_read_req = (issue_cnt_q < CNT_WPL);
        if (memory_read_req) issue_cnt_d = issue_cnt_q + CNT_ONE;
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          recv_cnt_d       = recv_cnt_q + CNT_ONE;
          // completion tracks the response count only, never latency
          if (recv_cnt_q == CNT_LAST) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // strobes stay quiet while reset is held
    if (rst) begin
      fsm_busy         = 1'b0;
      memory_read_req  = 1'b0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      offset_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
`ifdef CRITICAL_WORD_FIRST_EN
      offset_q    <= offset_d;
`endif
    end
  end
endmodule
